boot_sequencer: RTL and testbench

- Parametrised reconfiguration sequencer between the USB bootloader core and the FPGA PROGRAMN pin.
- Debounces the USB VBUS-detect input and runs a timed countdown. The countdown starts either from an explicit boot request (with a selectable image index) or from cable absence.
- At the end of the countdown it drives a fixed-width active-low PROGRAMN pulse.
- It also presents the latched image index to the external image-select logic.

---
 rtl/boot_sequencer_if.sv | 31 +++
 rtl/boot_sequencer.sv | 156 +++++++++++++++
 tb/tb_boot_sequencer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_sequencer_if.sv
// Bootloader-side signal bundle for boot_sequencer; the abort strobe exists only
// when BOOTSEQ_ABORT_EN is defined.
interface boot_sequencer_if #(
  parameter int IMG_W = 2
);
  // boot_req is a one-cycle strobe and boot_image is valid only alongside it.
  // There is no ready: the sequencer accepts a request in IDLE or ARM_AUTO and
  // silently drops it in every other state.
  logic             boot_req;
  logic [IMG_W-1:0] boot_image;
  logic             usb_vdet;
`ifdef BOOTSEQ_ABORT_EN
  logic             abort;
`endif
  logic             programn;
  logic [IMG_W-1:0] image_sel;
  logic             usb_present;
  logic             armed;

`ifdef BOOTSEQ_ABORT_EN
  modport master (output boot_req, boot_image, usb_vdet, abort,
                  input  programn, image_sel, usb_present, armed);
  modport slave  (input  boot_req, boot_image, usb_vdet, abort,
                  output programn, image_sel, usb_present, armed);
`else
  modport master (output boot_req, boot_image, usb_vdet,
                  input  programn, image_sel, usb_present, armed);
  modport slave  (input  boot_req, boot_image, usb_vdet,
                  output programn, image_sel, usb_present, armed);
`endif
endinterface

// File: rtl/boot_sequencer.sv
// VBUS debounce + timed PROGRAMN pulse generator. Optional abort: BOOTSEQ_ABORT_EN.
// o_dbg_state encoding: 0 IDLE, 1 ARM_AUTO, 2 ARM_REQ, 3 FIRE, 4 DONE.
module boot_sequencer #(
  parameter int DELAY_CYCLES    = 256,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int PULSE_CYCLES    = 4,
  parameter int IMG_W           = 2,
  parameter int DEFAULT_IMAGE   = 0
) (
  input  logic             clk,
  input  logic             resetn,
  boot_sequencer_if.slave  bus,
  output logic [2:0]       o_dbg_state
);
  localparam int CW = $clog2(DELAY_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [IMG_W-1:0] DEF_IMG = IMG_W'(DEFAULT_IMAGE);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ARM_AUTO = 3'd1, S_ARM_REQ = 3'd2, S_FIRE = 3'd3, S_DONE = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [PW-1:0]    r_pulse_cnt, w_pulse_nxt;
  logic [IMG_W-1:0] r_image, w_image_nxt;
  logic             r_programn, w_programn_nxt;
  logic             r_armed, w_armed_nxt;
  logic             r_sync1, r_sync2, r_usb_present;
  logic [DW-1:0]    r_deb_cnt;
  logic             w_abort, w_auto_ok;

  // Synchroniser presets to 1 so nothing auto-boots before VBUS is really seen absent.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_deb_cnt     <= '0;
      r_usb_present <= 1'b1;
    end else begin
      r_sync1 <= bus.usb_vdet;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_usb_present) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        r_usb_present <= r_sync2;
        r_deb_cnt     <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DW'(1);
      end
    end
  end

`ifdef BOOTSEQ_ABORT_EN
  // Blocks auto re-arm after an aborted auto-boot until VBUS has returned.
  logic r_abort_lat;
  assign w_abort   = bus.abort && (r_state == S_ARM_AUTO || r_state == S_ARM_REQ);
  assign w_auto_ok = !r_abort_lat;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                  r_abort_lat <= 1'b0;
    else if (w_abort && r_state == S_ARM_AUTO)    r_abort_lat <= 1'b1;
    else if (r_usb_present)                       r_abort_lat <= 1'b0;
  end
`else
  assign w_abort   = 1'b0;
  assign w_auto_ok = 1'b1;
`endif

  assign w_cnt_inc = (r_cnt == CW'(DELAY_CYCLES)) ? r_cnt : r_cnt + CW'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pulse_cnt <= '0;
      r_image     <= DEF_IMG;
      r_programn  <= 1'b1;
      r_armed     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pulse_cnt <= w_pulse_nxt;
      r_image     <= w_image_nxt;
      r_programn  <= w_programn_nxt;
      r_armed     <= w_armed_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pulse_nxt = r_pulse_cnt;
    w_image_nxt = r_image;
    case (r_state)
      S_IDLE: begin
        if (bus.boot_req) begin
          w_state_nxt = S_ARM_REQ;
          w_image_nxt = bus.boot_image;
          w_cnt_nxt   = '0;
        end else if (!r_usb_present && w_auto_ok) begin
          w_state_nxt = S_ARM_AUTO;
          w_image_nxt = DEF_IMG;
          w_cnt_nxt   = '0;
        end
      end
      S_ARM_AUTO: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_image_nxt = DEF_IMG;
        end else if (bus.boot_req) begin
          w_state_nxt = S_ARM_REQ;
          w_image_nxt = bus.boot_image;
          w_cnt_nxt   = '0;
        end else if (r_usb_present) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CW'(DELAY_CYCLES - 1)) begin
          w_state_nxt = S_FIRE;
          w_pulse_nxt = '0;
        end
      end
      S_ARM_REQ: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_image_nxt = DEF_IMG;
        end else if (r_cnt == CW'(DELAY_CYCLES - 1)) begin
          w_state_nxt = S_FIRE;
          w_pulse_nxt = '0;
        end
      end
      S_FIRE: begin
        w_pulse_nxt = r_pulse_cnt + PW'(1);
        if (r_pulse_cnt == PW'(PULSE_CYCLES - 1)) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so programn and armed are glitch-free.
  always_comb begin
    w_programn_nxt = (w_state_nxt != S_FIRE);
    w_armed_nxt    = (w_state_nxt == S_ARM_AUTO) || (w_state_nxt == S_ARM_REQ);
  end

  assign bus.programn    = r_programn;
  assign bus.image_sel   = r_image;
  assign bus.usb_present = r_usb_present;
  assign bus.armed       = r_armed;
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_boot_sequencer.sv
// Randomised bench for boot_sequencer against a timestamp-based reference model.
module tb_boot_sequencer;
  localparam int DELAY = 16;
  localparam int DEB   = 4;
  localparam int PULSE = 3;
  localparam int IMG_W = 2;
  localparam int DEF   = 0;

  localparam int M_IDLE = 0, M_AUTO = 1, M_REQ = 2, M_FIRE = 3, M_DONE = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] dbg_state;

  boot_sequencer_if #(.IMG_W(IMG_W)) bus();

  boot_sequencer #(
    .DELAY_CYCLES(DELAY), .DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(PULSE),
    .IMG_W(IMG_W), .DEFAULT_IMAGE(DEF)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int low_cnt;

  // ---------------- reference model ----------------
  int               m_mode;
  int               m_arm_edge;
  int               m_fire_edge;
  logic [IMG_W-1:0] m_img;
  logic             m_present;
  logic             m_lockout;
  logic             m_pin_q[$];

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_img     = IMG_W'(DEF);
    m_present = 1'b1;
    m_lockout = 1'b0;
    m_pin_q.delete();
    for (int i = 0; i < DEB + 2; i++) m_pin_q.push_back(1'b1);
  endtask

  task automatic model_arm(input int mode, input logic [IMG_W-1:0] img);
    m_mode     = mode;
    m_img      = img;
    m_arm_edge = cyc;
  endtask

  // Applies one clock edge: FSM sees the pre-edge debounced value.
  task automatic model_edge();
    logic ab;
    logic flip;
    ab = 1'b0;
`ifdef BOOTSEQ_ABORT_EN
    ab = bus.abort;
`endif
    if (m_present) m_lockout = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (bus.boot_req)                   model_arm(M_REQ, bus.boot_image);
        else if (!m_present && !m_lockout)  model_arm(M_AUTO, IMG_W'(DEF));
      end
      M_AUTO: begin
        if (ab) begin
          m_mode = M_IDLE; m_img = IMG_W'(DEF); m_lockout = 1'b1;
        end else if (bus.boot_req)          model_arm(M_REQ, bus.boot_image);
        else if (m_present)                 m_mode = M_IDLE;
        else if (cyc == m_arm_edge + DELAY) begin m_mode = M_FIRE; m_fire_edge = cyc; end
      end
      M_REQ: begin
        if (ab) begin
          m_mode = M_IDLE; m_img = IMG_W'(DEF);
        end else if (cyc == m_arm_edge + DELAY) begin m_mode = M_FIRE; m_fire_edge = cyc; end
      end
      M_FIRE: if (cyc == m_fire_edge + PULSE) m_mode = M_DONE;
      default: ;
    endcase
    // usb_present flips once DEB consecutive synchronised samples disagree with it.
    m_pin_q.push_back(bus.usb_vdet);
    void'(m_pin_q.pop_front());
    flip = 1'b1;
    for (int i = 0; i < DEB; i++) if (m_pin_q[i] == m_present) flip = 1'b0;
    if (flip) m_present = ~m_present;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic compare_all();
    check("programn",    32'(bus.programn),    32'(m_mode != M_FIRE));
    check("armed",       32'(bus.armed),       32'(m_mode == M_AUTO || m_mode == M_REQ));
    check("image_sel",   32'(bus.image_sel),   32'(m_img));
    check("usb_present", 32'(bus.usb_present), 32'(m_present));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare_all();
    if (bus.programn === 1'b0) low_cnt++;
    bus.boot_req = 1'b0;
`ifdef BOOTSEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
    low_cnt = 0;
  endtask

  task automatic send_req(input logic [IMG_W-1:0] img);
    bus.boot_req   = 1'b1;
    bus.boot_image = img;
    tick();
  endtask

  task automatic wait_mode(input int mode, input int budget);
    for (int i = 0; i < budget && m_mode != mode; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [IMG_W-1:0] img;
    int               n;
    resetn         = 1'b0;
    bus.boot_req   = 1'b0;
    bus.boot_image = '0;
    bus.usb_vdet   = 1'b1;
`ifdef BOOTSEQ_ABORT_EN
    bus.abort      = 1'b0;
`endif

    // Reset values and explicit request with image 2; second request ignored.
    do_reset();
    #1;
    check("rst_programn", 32'(bus.programn), 32'd1);
    check("rst_image",    32'(bus.image_sel), 32'(DEF));
    check("rst_present",  32'(bus.usb_present), 32'd1);
    check("rst_armed",    32'(bus.armed), 32'd0);
    check("rst_state",    32'(dbg_state), 32'd0);
    ticks($urandom_range(1, 5));
    send_req(2'd2);
    ticks(DELAY + PULSE + 4);
    send_req(2'(3));
    ticks(DELAY + PULSE + 4);
    check("req_pulse_width", 32'(low_cnt), 32'(PULSE));
    check("done_state", 32'(dbg_state), 32'd4);

    // Cable absence auto-boot.
    do_reset();
    ticks($urandom_range(0, 3));
    bus.usb_vdet = 1'b0;
    ticks(DEB + 2 + DELAY + PULSE + 6);
    check("auto_pulse_width", 32'(low_cnt), 32'(PULSE));

    // Cable returns mid-countdown: cancel, no pulse.
    do_reset();
    bus.usb_vdet = 1'b0;
    wait_mode(M_AUTO, 40);
    ticks($urandom_range(3, 7));
    bus.usb_vdet = 1'b1;
    ticks(DELAY + PULSE + 10);
    check("cancel_no_pulse", 32'(low_cnt), 32'd0);
    check("cancel_idle", 32'(dbg_state), 32'd0);

    // Short VBUS glitches never propagate.
    do_reset();
    for (int g = 0; g < 4; g++) begin
      bus.usb_vdet = 1'b0;
      ticks($urandom_range(1, DEB - 1));
      bus.usb_vdet = 1'b1;
      ticks($urandom_range(1, 6));
    end
    ticks(8);
    check("glitch_no_pulse", 32'(low_cnt), 32'd0);

    // Request during auto countdown overrides, then cable return cannot cancel.
    do_reset();
    bus.usb_vdet = 1'b0;
    wait_mode(M_AUTO, 40);
    ticks(8);
    send_req(2'd3);
    ticks($urandom_range(2, 5));
    bus.usb_vdet = 1'b1;
    ticks(DELAY + PULSE + 6);
    check("override_pulse_width", 32'(low_cnt), 32'(PULSE));

    // Asynchronous reset in the middle of the pulse.
    do_reset();
    send_req(IMG_W'($urandom_range(0, 3)));
    wait_mode(M_FIRE, 40);
    ticks(1);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_programn", 32'(bus.programn), 32'd1);
    check("async_rst_state",    32'(dbg_state), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    low_cnt = 0;
    ticks(5);

`ifdef BOOTSEQ_ABORT_EN
    // Abort an explicit request, then abort an auto-boot and check the re-arm lockout.
    do_reset();
    send_req(2'd1);
    ticks($urandom_range(2, DELAY - 3));
    bus.abort = 1'b1;
    bus.boot_req = 1'b1;
    tick();
    ticks(DELAY + 6);
    check("abort_req_no_pulse", 32'(low_cnt), 32'd0);
    bus.usb_vdet = 1'b0;
    wait_mode(M_AUTO, 40);
    ticks(3);
    bus.abort = 1'b1;
    tick();
    ticks(DELAY + 6);
    check("abort_auto_locked", 32'(bus.armed), 32'd0);
    bus.usb_vdet = 1'b1;
    ticks(DEB + 5);
    bus.usb_vdet = 1'b0;
    ticks(DEB + DELAY + PULSE + 8);
    check("abort_rearm_pulse", 32'(low_cnt), 32'(PULSE));
`endif

    // Random soak rounds.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      n = 0;
      for (int c = 0; c < 120; c++) begin
        if (n == 0) begin
          bus.usb_vdet = ($urandom_range(0, 2) != 0) ? ~bus.usb_vdet : bus.usb_vdet;
          n = $urandom_range(1, 14);
        end
        n--;
        if ($urandom_range(0, 39) == 0) begin
          img = IMG_W'($urandom_range(0, 3));
          bus.boot_req   = 1'b1;
          bus.boot_image = img;
        end
`ifdef BOOTSEQ_ABORT_EN
        if ($urandom_range(0, 29) == 0) bus.abort = 1'b1;
`endif
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation exceeded its time budget");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
